// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared PPU definitions used by the Mode 7 configuration front-end:
//   - B-bus register addresses (low byte of $21xx) for the Mode 7 block
//   - register-select enum produced by the address decoder
//   - multiplier state enum and operand/product widths
//   - helpers for address decode and 13-bit scroll/origin assembly
// ---------------------------------------------------------------------------
package ppu_pkg;

  // B-bus register addresses ($21xx low byte)
  localparam logic [7:0] ADDR_BG1HOFS = 8'h0D;
  localparam logic [7:0] ADDR_BG1VOFS = 8'h0E;
  localparam logic [7:0] ADDR_M7SEL   = 8'h1A;
  localparam logic [7:0] ADDR_M7A     = 8'h1B;
  localparam logic [7:0] ADDR_M7B     = 8'h1C;
  localparam logic [7:0] ADDR_M7C     = 8'h1D;
  localparam logic [7:0] ADDR_M7D     = 8'h1E;
  localparam logic [7:0] ADDR_M7X     = 8'h1F;
  localparam logic [7:0] ADDR_M7Y     = 8'h20;

  // Multiplier geometry: signed 16-bit matrix value times signed 8-bit byte
  localparam int MUL_A_W = 16;
  localparam int MUL_B_W = 8;
  localparam int MUL_P_W = 24;

  // Which Mode 7 register (if any) a B-bus write targets
  typedef enum logic [3:0] {
    REG_NONE,
    REG_M7SEL,
    REG_M7A,
    REG_M7B,
    REG_M7C,
    REG_M7D,
    REG_XOFS,
    REG_YOFS,
    REG_XORIG,
    REG_YORIG
  } m7_reg_e;

  // Sequential multiplier control state
  typedef enum logic {
    MUL_IDLE,
    MUL_RUN
  } mul_state_e;

  // Map a B-bus address to its Mode 7 register; anything else is REG_NONE
  function automatic m7_reg_e decode_addr(input logic [7:0] addr);
    m7_reg_e sel;
    case (addr)
      ADDR_M7SEL:   sel = REG_M7SEL;
      ADDR_M7A:     sel = REG_M7A;
      ADDR_M7B:     sel = REG_M7B;
      ADDR_M7C:     sel = REG_M7C;
      ADDR_M7D:     sel = REG_M7D;
      ADDR_BG1HOFS: sel = REG_XOFS;
      ADDR_BG1VOFS: sel = REG_YOFS;
      ADDR_M7X:     sel = REG_XORIG;
      ADDR_M7Y:     sel = REG_YORIG;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

  // Scroll/origin registers keep only 5 bits of the high byte (13-bit signed)
  function automatic logic [12:0] join13(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[4:0], lo};
  endfunction

endpackage

// File: rtl/m7_mul_seq.sv
// ---------------------------------------------------------------------------
// m7_mul_seq
// Iterative signed 16x8 shift-add multiplier behind MPYL/M/H.
// Consumes BITS_PER_CYCLE multiplier bits per clock, LSB first, so a product
// takes STEPS = 8/BITS_PER_CYCLE clocks after the start edge. The top bit of
// b carries weight -128 (two's complement), so the last partial product is
// subtracted instead of added. A start always wins, aborting any run.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-low reset
//   start   in   load operands and (re)start a multiply on this edge
//   a       in   16-bit signed multiplicand
//   b       in   8-bit signed multiplier
//   result  out  24-bit signed product, updated only when a run completes
//   busy    out  high while a multiply is in progress
//
// BITS_PER_CYCLE must be 1, 2, 4 or 8.
// ---------------------------------------------------------------------------
module m7_mul_seq
  import ppu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MUL_A_W-1:0] a,
  input  logic [MUL_B_W-1:0] b,
  output logic [MUL_P_W-1:0] result,
  output logic               busy
);

  localparam int STEPS = MUL_B_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  mul_state_e         state_reg,  state_next;
  logic [MUL_P_W-1:0] mcand_reg,  mcand_next;
  logic [MUL_B_W-1:0] mplier_reg, mplier_next;
  logic [MUL_P_W-1:0] acc_reg,    acc_next;
  logic [MUL_P_W-1:0] result_reg, result_next;
  logic [CNT_W-1:0]   count_reg,  count_next;

  logic               last_step;
  logic [MUL_P_W-1:0] term [BITS_PER_CYCLE];
  logic [MUL_P_W-1:0] chunk_sum;

  // The final step of a run holds multiplier bit 7, the sign bit
  assign last_step = (count_reg == CNT_W'(1));

  // One partial product per multiplier bit handled this cycle. The
  // multiplicand register is already shifted to the current bit position.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (last_step && (i == BITS_PER_CYCLE - 1)) begin
        chunk_sum = chunk_sum - term[i];
      end else begin
        chunk_sum = chunk_sum + term[i];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    count_next  = count_reg;

    if (start) begin
      state_next  = MUL_RUN;
      mcand_next  = {{(MUL_P_W - MUL_A_W){a[MUL_A_W-1]}}, a};
      mplier_next = b;
      acc_next    = '0;
      count_next  = CNT_W'(STEPS);
    end else if (state_reg == MUL_RUN) begin
      acc_next    = acc_reg + chunk_sum;
      mcand_next  = mcand_reg << BITS_PER_CYCLE;
      mplier_next = mplier_reg >> BITS_PER_CYCLE;
      count_next  = count_reg - CNT_W'(1);
      if (last_step) begin
        // Publish the whole product at once; result never shows partials
        result_next = acc_reg + chunk_sum;
        state_next  = MUL_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= MUL_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      count_reg  <= count_next;
    end
  end

  assign result = result_reg;
  assign busy   = (state_reg == MUL_RUN);

endmodule

// File: rtl/m7_reg_ctrl.sv
// ---------------------------------------------------------------------------
// m7_reg_ctrl
// Mode 7 configuration front-end. Decodes CPU B-bus writes to $210D/$210E
// and $211A-$2120, implements the shared Mode 7 write-twice latch, and
// drives the static configuration inputs of the Mode 7 BG renderer. Writes
// to M7A/M7B also kick off the MPYL/M/H multiply of m7_a by m7_b[15:8].
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   cpu_we     in   one-cycle write strobe
//   cpu_addr   in   B-bus address low byte ($21xx)
//   cpu_wdata  in   write data
//   m7sel      out  {screen_over[1:0], yflip, xflip}
//   m7_a..d    out  matrix A..D, two's complement 8.8
//   m7_xofs    out  13-bit signed horizontal scroll
//   m7_yofs    out  13-bit signed vertical scroll
//   m7_xorig   out  13-bit signed X rotation origin
//   m7_yorig   out  13-bit signed Y rotation origin
//   mpy        out  24-bit signed product m7_a * m7_b[15:8]
//   mpy_busy   out  multiply in progress
// ---------------------------------------------------------------------------
module m7_reg_ctrl
  import ppu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_we,
  input  logic [7:0]         cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [3:0]         m7sel,
  output logic [15:0]        m7_a,
  output logic [15:0]        m7_b,
  output logic [15:0]        m7_c,
  output logic [15:0]        m7_d,
  output logic [12:0]        m7_xofs,
  output logic [12:0]        m7_yofs,
  output logic [12:0]        m7_xorig,
  output logic [12:0]        m7_yorig,
  output logic [MUL_P_W-1:0] mpy,
  output logic               mpy_busy
);

  m7_reg_e     sel;
  logic [7:0]  m7_old_reg;
  logic [3:0]  m7sel_reg;
  logic [15:0] m7_a_reg, m7_b_reg, m7_c_reg, m7_d_reg;
  logic [12:0] xofs_reg, yofs_reg, xorig_reg, yorig_reg;

  logic               mul_start;
  logic [MUL_A_W-1:0] mul_a;
  logic [MUL_B_W-1:0] mul_b;

  always_comb begin
    sel = REG_NONE;
    if (cpu_we) begin
      sel = decode_addr(cpu_addr);
    end
  end

  // Every written register pairs the new byte with whatever byte was
  // written last; there is no low/high phase tracking. M7SEL is the only
  // decoded register that leaves the latch alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m7_old_reg <= '0;
      m7sel_reg  <= '0;
      m7_a_reg   <= '0;
      m7_b_reg   <= '0;
      m7_c_reg   <= '0;
      m7_d_reg   <= '0;
      xofs_reg   <= '0;
      yofs_reg   <= '0;
      xorig_reg  <= '0;
      yorig_reg  <= '0;
    end else begin
      case (sel)
        REG_M7SEL: m7sel_reg <= {cpu_wdata[7:6], cpu_wdata[1:0]};
        REG_M7A:   m7_a_reg  <= {cpu_wdata, m7_old_reg};
        REG_M7B:   m7_b_reg  <= {cpu_wdata, m7_old_reg};
        REG_M7C:   m7_c_reg  <= {cpu_wdata, m7_old_reg};
        REG_M7D:   m7_d_reg  <= {cpu_wdata, m7_old_reg};
        REG_XOFS:  xofs_reg  <= join13(cpu_wdata, m7_old_reg);
        REG_YOFS:  yofs_reg  <= join13(cpu_wdata, m7_old_reg);
        REG_XORIG: xorig_reg <= join13(cpu_wdata, m7_old_reg);
        REG_YORIG: yorig_reg <= join13(cpu_wdata, m7_old_reg);
        default: ;
      endcase
      if ((sel != REG_NONE) && (sel != REG_M7SEL)) begin
        m7_old_reg <= cpu_wdata;
      end
    end
  end

  // The multiplier samples its operands on the same edge as the register
  // write, so feed it the post-write values rather than the current ones.
  assign mul_start = (sel == REG_M7A) || (sel == REG_M7B);
  assign mul_a     = (sel == REG_M7A) ? {cpu_wdata, m7_old_reg} : m7_a_reg;
  assign mul_b     = (sel == REG_M7B) ? cpu_wdata : m7_b_reg[15:8];

  m7_mul_seq #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (mul_a),
    .b      (mul_b),
    .result (mpy),
    .busy   (mpy_busy)
  );

  assign m7sel    = m7sel_reg;
  assign m7_a     = m7_a_reg;
  assign m7_b     = m7_b_reg;
  assign m7_c     = m7_c_reg;
  assign m7_d     = m7_d_reg;
  assign m7_xofs  = xofs_reg;
  assign m7_yofs  = yofs_reg;
  assign m7_xorig = xorig_reg;
  assign m7_yorig = yorig_reg;

endmodule

// File: tb/tb_m7_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_m7_reg_ctrl
// Drives four m7_reg_ctrl instances (BITS_PER_CYCLE = 1, 2, 4, 8) from one
// shared write stream and checks registers, products and multiply latency
// against hand-computed values and a signed reference product.
// ---------------------------------------------------------------------------
module tb_m7_reg_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_wdata;

  logic [3:0]  m7sel_w    [4];
  logic [15:0] m7_a_w     [4];
  logic [15:0] m7_b_w     [4];
  logic [15:0] m7_c_w     [4];
  logic [15:0] m7_d_w     [4];
  logic [12:0] m7_xofs_w  [4];
  logic [12:0] m7_yofs_w  [4];
  logic [12:0] m7_xorig_w [4];
  logic [12:0] m7_yorig_w [4];
  logic [23:0] mpy_w      [4];
  logic        busy_w     [4];

  logic [23:0] last_mpy   [4];
  int          n_checks;
  int          n_errors;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      m7_reg_ctrl #(
        .BITS_PER_CYCLE(1 << gi)
      ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .m7sel     (m7sel_w[gi]),
        .m7_a      (m7_a_w[gi]),
        .m7_b      (m7_b_w[gi]),
        .m7_c      (m7_c_w[gi]),
        .m7_d      (m7_d_w[gi]),
        .m7_xofs   (m7_xofs_w[gi]),
        .m7_yofs   (m7_yofs_w[gi]),
        .m7_xorig  (m7_xorig_w[gi]),
        .m7_yorig  (m7_yorig_w[gi]),
        .mpy       (mpy_w[gi]),
        .mpy_busy  (busy_w[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed reference: 16-bit a times 8-bit b, truncated to 24 bits
  function automatic logic [23:0] ref_mul(input logic [15:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[23:0];
  endfunction

  // Called just after a negedge; the write lands on the following posedge
  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    @(negedge clk);
    cpu_we    = 1'b0;
  endtask

  // Called right after the starting write; checks busy/mpy every cycle
  // until the slowest instance (8 cycles) has finished.
  task automatic wait_product(input logic [23:0] prod, input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s busy%0d k0", tag, d), 32'(busy_w[d]), 32'd1);
      check($sformatf("%s mpy%0d k0", tag, d), 32'(mpy_w[d]), 32'(last_mpy[d]));
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        check($sformatf("%s busy%0d k%0d", tag, d, k), 32'(busy_w[d]),
              (k < (8 >> d)) ? 32'd1 : 32'd0);
        check($sformatf("%s mpy%0d k%0d", tag, d, k), 32'(mpy_w[d]),
              (k >= (8 >> d)) ? 32'(prod) : 32'(last_mpy[d]));
      end
    end
    for (int d = 0; d < 4; d++) last_mpy[d] = prod;
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s mpy%0d", tag, d), 32'(mpy_w[d]), 32'd0);
      check($sformatf("%s busy%0d", tag, d), 32'(busy_w[d]), 32'd0);
    end
    check({tag, " m7sel"}, 32'(m7sel_w[0]), 32'd0);
    check({tag, " m7_a"}, 32'(m7_a_w[0]), 32'd0);
    check({tag, " m7_b"}, 32'(m7_b_w[0]), 32'd0);
    check({tag, " m7_c"}, 32'(m7_c_w[0]), 32'd0);
    check({tag, " m7_d"}, 32'(m7_d_w[0]), 32'd0);
    check({tag, " xofs"}, 32'(m7_xofs_w[0]), 32'd0);
    check({tag, " yofs"}, 32'(m7_yofs_w[0]), 32'd0);
    check({tag, " xorig"}, 32'(m7_xorig_w[0]), 32'd0);
    check({tag, " yorig"}, 32'(m7_yorig_w[0]), 32'd0);
  endtask

  // Corner operand pairs run before the random sweep
  logic [15:0] corner_a [6] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
  logic [7:0]  corner_b [6] = '{8'h80,    8'h7F,    8'h80,    8'h01,    8'h7F,    8'h80};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    n_checks  = 0;
    n_errors  = 0;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    reset     = 1'b1;
    for (int d = 0; d < 4; d++) last_mpy[d] = '0;

    // Reset state
    #2 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Write-twice A and B, basic product
    wr(8'h1B, 8'h34);
    wr(8'h1B, 8'h12);
    check("a_1234", 32'(m7_a_w[0]), 32'h1234);
    wr(8'h1C, 8'h00);
    check("b_0012", 32'(m7_b_w[0]), 32'h0012);
    wr(8'h1C, 8'h02);
    check("b_0200", 32'(m7_b_w[0]), 32'h0200);
    wait_product(24'h002468, "mpy_2468");

    // Shared latch across A and B
    wr(8'h1B, 8'hAA);
    check("a_aa02", 32'(m7_a_w[0]), 32'hAA02);
    wr(8'h1C, 8'hBB);
    check("b_bbaa", 32'(m7_b_w[0]), 32'hBBAA);
    wait_product(24'h172D76, "mpy_aa02_bb");

    // Signed corner products
    wr(8'h1B, 8'hFF);
    wr(8'h1B, 8'hFF);
    check("a_ffff", 32'(m7_a_w[0]), 32'hFFFF);
    wr(8'h1C, 8'h00);
    wr(8'h1C, 8'h80);
    check("b_8000", 32'(m7_b_w[0]), 32'h8000);
    wait_product(24'h000080, "mpy_m1_m128");
    wr(8'h1B, 8'h00);
    wr(8'h1B, 8'h80);
    check("a_8000", 32'(m7_a_w[0]), 32'h8000);
    wait_product(24'h400000, "mpy_max");

    // 13-bit truncation, M7SEL, remaining registers
    wr(8'h0D, 8'hFF);
    wr(8'h0D, 8'hFF);
    check("xofs_1fff", 32'(m7_xofs_w[0]), 32'h1FFF);
    wr(8'h1A, 8'hC3);
    check("m7sel_f", 32'(m7sel_w[0]), 32'hF);
    wr(8'h0E, 8'h01);
    check("yofs_01ff", 32'(m7_yofs_w[0]), 32'h01FF);
    wr(8'h1F, 8'h05);
    check("xorig_0501", 32'(m7_xorig_w[0]), 32'h0501);
    wr(8'h20, 8'h2A);
    check("yorig_0a05", 32'(m7_yorig_w[0]), 32'h0A05);
    wr(8'h1D, 8'h11);
    check("c_112a", 32'(m7_c_w[0]), 32'h112A);
    wr(8'h1E, 8'h22);
    check("d_2211", 32'(m7_d_w[0]), 32'h2211);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("nostart busy%0d", d), 32'(busy_w[d]), 32'd0);
      check($sformatf("nostart mpy%0d", d), 32'(mpy_w[d]), 32'h400000);
    end

    // No write without cpu_we; unlisted addresses ignored
    cpu_addr  = 8'h1B;
    cpu_wdata = 8'h55;
    @(negedge clk);
    check("nowe a", 32'(m7_a_w[0]), 32'h8000);
    check("nowe busy", 32'(busy_w[0]), 32'd0);
    wr(8'h21, 8'h77);
    wr(8'h0F, 8'h66);
    check("unlisted yorig", 32'(m7_yorig_w[0]), 32'h0A05);
    check("unlisted m7sel", 32'(m7sel_w[0]), 32'hF);
    wr(8'h1D, 8'h33);
    check("c_3322", 32'(m7_c_w[0]), 32'h3322);

    // Restart while busy: 0x8000*3 started, replaced two cycles later
    wr(8'h1C, 8'h03);
    check("b_0333", 32'(m7_b_w[0]), 32'h0333);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("restart busy%0d k1", d), 32'(busy_w[d]), (d == 3) ? 32'd0 : 32'd1);
      check($sformatf("restart mpy%0d k1", d), 32'(mpy_w[d]),
            (d == 3) ? 32'hFE8000 : 32'h400000);
    end
    last_mpy[3] = 24'hFE8000;
    wr(8'h1B, 8'h01);
    check("a_0103", 32'(m7_a_w[0]), 32'h0103);
    wait_product(24'h000309, "mpy_restart");

    // Asynchronous reset mid-multiply
    wr(8'h1B, 8'h05);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 4; d++) last_mpy[d] = '0;
    wr(8'h1B, 8'h7F);
    check("latch_cleared a", 32'(m7_a_w[0]), 32'h7F00);
    wait_product(24'h000000, "mpy_after_reset");

    // Corner and random sweep on all four BITS_PER_CYCLE settings
    for (int i = 0; i < 1000; i++) begin
      if (i < 6) begin
        ra = corner_a[i];
        rb = corner_b[i];
      end else begin
        ra = 16'($urandom);
        rb = 8'($urandom);
      end
      wr(8'h1B, ra[7:0]);
      wr(8'h1B, ra[15:8]);
      wr(8'h1C, rb);
      check($sformatf("sweep%0d a", i), 32'(m7_a_w[0]), 32'(ra));
      wait_product(ref_mul(ra, rb), $sformatf("sweep%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
